// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue: packet layout,
// NOP encoding and the empty-queue head value.
package inst_fetch_queue_pkg;

    localparam int PC_W        = 32;
    localparam int INST_W      = 32;
    localparam int TAKEN_W     = 2;
    localparam int EXCP_W      = 7;
    localparam int EXCP_FLAG_W = 2;

    // andi r0, r0, 0
    localparam logic [INST_W-1:0] INST_NOP = 32'h0340_0000;

    typedef struct packed {
        logic [PC_W-1:0]        pc;
        logic [PC_W-1:0]        pc_next;
        logic [PC_W-1:0]        badv;
        logic [TAKEN_W-1:0]     pc_taken;
        logic [INST_W-1:0]      inst0;
        logic [INST_W-1:0]      inst1;
        logic [EXCP_W-1:0]      exception;
        logic [EXCP_FLAG_W-1:0] excp_flag;
    } fetch_pkt_t;

    localparam int FETCH_PKT_W = $bits(fetch_pkt_t);

    // Head value presented to decode while the queue is empty.
    localparam fetch_pkt_t EMPTY_PKT = '{inst0: INST_NOP, inst1: INST_NOP, default: '0};

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// Packet storage: DEPTH x FETCH_PKT_W, synchronous write, combinational read.
module fetch_queue_ram
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [LOG_DEPTH-1:0]   waddr,
    input  logic [FETCH_PKT_W-1:0] wdata,
    input  logic [LOG_DEPTH-1:0]   raddr,
    output logic [FETCH_PKT_W-1:0] rdata
);

    logic [FETCH_PKT_W-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // pointers and count, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Packet-level instruction queue between IF1 and decode: circular buffer with
// registered pointers/count, no full or empty bypass, empty-forced head fields.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [PC_W-1:0]          in_pc_next,
    input  logic [PC_W-1:0]          in_badv,
    input  logic [TAKEN_W-1:0]       in_pc_taken,
    input  logic [INST_W-1:0]        in_inst0,
    input  logic [INST_W-1:0]        in_inst1,
    input  logic [EXCP_W-1:0]        in_exception,
    input  logic [EXCP_FLAG_W-1:0]   in_excp_flag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [PC_W-1:0]          out_pc_next,
    output logic [PC_W-1:0]          out_badv,
    output logic [TAKEN_W-1:0]       out_pc_taken,
    output logic [INST_W-1:0]        out_inst0,
    output logic [INST_W-1:0]        out_inst1,
    output logic [EXCP_W-1:0]        out_exception,
    output logic [EXCP_FLAG_W-1:0]   out_excp_flag,
    output logic                     space_ok,
    output logic                     nearly_full,
    output logic [LOG_DEPTH:0]       count
);

    localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH+1)'(DEPTH);

    logic [LOG_DEPTH-1:0] rd_ptr, wr_ptr;
    logic [LOG_DEPTH:0]   free_cnt;
    logic                 push, pop;
    fetch_pkt_t           in_pkt, ram_pkt, head;

    assign in_pkt = '{pc: in_pc, pc_next: in_pc_next, badv: in_badv,
                      pc_taken: in_pc_taken, inst0: in_inst0, inst1: in_inst1,
                      exception: in_exception, excp_flag: in_excp_flag};

    // Handshakes depend on registered count only, keeping in_valid/out_ready
    // off the in_ready/out_valid paths.
    assign in_ready  = (count != DEPTH_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign free_cnt    = DEPTH_CNT - count;
    assign space_ok    = (free_cnt >= (LOG_DEPTH+1)'(2));
    assign nearly_full = (free_cnt == (LOG_DEPTH+1)'(1));

    fetch_queue_ram #(
        .DEPTH     (DEPTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (in_pkt),
        .raddr (rd_ptr),
        .rdata (ram_pkt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = out_valid ? ram_pkt : EMPTY_PKT;

    assign out_pc        = head.pc;
    assign out_pc_next   = head.pc_next;
    assign out_badv      = head.badv;
    assign out_pc_taken  = head.pc_taken;
    assign out_inst0     = head.inst0;
    assign out_inst1     = head.inst1;
    assign out_exception = head.exception;
    assign out_excp_flag = head.excp_flag;

endmodule
